// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath/SRAM.
// Timing contract (no valid/ready pair): controller outputs are combinational from its state and
// are valid for the whole cycle. op_code and alu_function are held from DECODE until the
// instruction returns to FETCH. zero is sampled in BRANCH.
interface multicycle_control_if;
  logic [5:0] op_code;
  logic [5:0] alu_function;
  logic       zero;
  logic       cs;
  logic       oe;
  logic       rw;
  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       alu_src;
  logic       mem_to_reg;
  logic       branch;
  logic       jump;
  logic       jump_reg;
  logic [5:0] alu_op;
  logic [3:0] state;
  logic       illegal;

  modport master (
    input  op_code, alu_function, zero,
    output cs, oe, rw, pc_write, ir_write, reg_write, reg_dst, alu_src,
           mem_to_reg, branch, jump, jump_reg, alu_op, state, illegal
  );

  modport slave (
    output op_code, alu_function, zero,
    input  cs, oe, rw, pc_write, ir_write, reg_write, reg_dst, alu_src,
           mem_to_reg, branch, jump, jump_reg, alu_op, state, illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset controller: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencing with a
// shared active-low SRAM port whose accesses last MEM_WAIT+1 cycles.
module multicycle_control #(
  parameter int MEM_WAIT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_control_if.master  bus
);
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXECUTE   = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WRITE = 4'd4,
    WRITEBACK = 4'd5,
    BRANCH    = 4'd6,
    JUMP      = 4'd7,
    ILLEGAL   = 4'd8
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  logic       active_q;
  logic       in_access;
  logic       done;

  assign in_access = (state_q == FETCH) || (state_q == MEM_READ) || (state_q == MEM_WRITE);
  assign done      = (cnt_q == WAIT_LAST);

  // active_q holds the machine idle for the partial cycle after reset release, so the first
  // rising edge starts FETCH with the counter at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH;
      cnt_q    <= 4'd0;
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
      state_q  <= state_d;
      if (state_d != state_q)
        cnt_q <= 4'd0;
      else if (active_q && in_access)
        cnt_q <= cnt_q + 4'd1;
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.cs         = 1'b1;
    bus.oe         = 1'b1;
    bus.rw         = 1'b1;
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.alu_src    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.branch     = 1'b0;
    bus.jump       = 1'b0;
    bus.jump_reg   = 1'b0;
    bus.alu_op     = ALU_ADD;
    bus.illegal    = 1'b0;
    if (active_q) begin
      case (state_q)
        FETCH: begin
          bus.cs = 1'b0;
          bus.oe = 1'b0;
          if (done) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            state_d      = DECODE;
          end
        end
        DECODE: begin
          case (bus.op_code)
            OP_RTYPE:              state_d = (bus.alu_function == FN_JR) ? JUMP : EXECUTE;
            OP_LW, OP_SW, OP_ADDI: state_d = EXECUTE;
            OP_BEQ, OP_BNE:        state_d = BRANCH;
            OP_J:                  state_d = JUMP;
            default:               state_d = ILLEGAL;
          endcase
        end
        EXECUTE: begin
          if (bus.op_code == OP_RTYPE) begin
            bus.alu_op = bus.alu_function;
          end else begin
            bus.alu_src = 1'b1;
          end
          if (bus.op_code == OP_LW)      state_d = MEM_READ;
          else if (bus.op_code == OP_SW) state_d = MEM_WRITE;
          else                           state_d = WRITEBACK;
        end
        MEM_READ: begin
          bus.cs      = 1'b0;
          bus.oe      = 1'b0;
          bus.alu_src = 1'b1;
          if (done) state_d = WRITEBACK;
        end
        MEM_WRITE: begin
          bus.cs      = 1'b0;
          bus.rw      = 1'b0;
          bus.alu_src = 1'b1;
          if (done) state_d = FETCH;
        end
        WRITEBACK: begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = (bus.op_code == OP_RTYPE);
          bus.mem_to_reg = (bus.op_code == OP_LW);
          state_d        = FETCH;
        end
        BRANCH: begin
          bus.alu_op   = ALU_SUB;
          bus.branch   = 1'b1;
          bus.pc_write = (bus.op_code == OP_BEQ) ? bus.zero : !bus.zero;
          state_d      = FETCH;
        end
        JUMP: begin
          bus.pc_write = 1'b1;
          bus.jump     = (bus.op_code == OP_J);
          bus.jump_reg = (bus.op_code == OP_RTYPE);
          state_d      = FETCH;
        end
        ILLEGAL: begin
          bus.illegal = 1'b1;
        end
        default: state_d = ILLEGAL;
      endcase
    end
  end

  assign bus.state = state_q;
endmodule
